// File: rtl/commit_monitor.sv
// commit_monitor: retirement-side observer for the writeback stream.
// Counts cycles and retired instructions, detects program halt (halt
// instruction or a PC that keeps committing), and buffers committed
// PC/instruction pairs in a first-word fall-through trace FIFO.
module commit_monitor #(
  parameter int unsigned          ADDR_SIZE   = 32,
  parameter int unsigned          TRACE_DEPTH = 8,
  parameter int unsigned          HALT_REPEAT = 4,
  parameter logic [ADDR_SIZE-1:0] HALT_INSTR  = 32'h0000006f
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           wb_valid,
  input  logic [ADDR_SIZE-1:0]           wb_pc,
  input  logic [ADDR_SIZE-1:0]           wb_instr,
  input  logic                           trace_rd_en,
  output logic                           trace_valid,
  output logic [ADDR_SIZE-1:0]           trace_pc,
  output logic [ADDR_SIZE-1:0]           trace_instr,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_overflow,
  output logic [63:0]                    cycle_cnt,
  output logic [63:0]                    instret_cnt,
  output logic                           halted,
  output logic [ADDR_SIZE-1:0]           halt_pc,
  output logic                           done
);

  localparam int unsigned PW = $clog2(TRACE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = $clog2(HALT_REPEAT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(TRACE_DEPTH);
  localparam logic [RW-1:0] REP_MAX  = RW'(HALT_REPEAT);
  localparam logic [RW-1:0] REP_ONE  = RW'(1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_SIZE-1:0] mem_pc_q    [TRACE_DEPTH];
  logic [ADDR_SIZE-1:0] mem_instr_q [TRACE_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q;
  logic [63:0]          cycle_q, instret_q;
  logic [ADDR_SIZE-1:0] halt_pc_q;
  logic [ADDR_SIZE-1:0] last_pc_q, last_pc_d;
  logic [RW-1:0]        rep_q, rep_d;

  logic accept, halt_trig, fifo_full, fifo_empty, do_push, do_pop;

  // Commit acceptance, repeat tracking and FIFO push/pop decisions.
  always_comb begin
    accept     = wb_valid && (state_q == RUN);
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    do_pop     = trace_rd_en && !fifo_empty;
    // a full FIFO still takes the push when the head leaves in the same cycle
    do_push    = accept && (!fifo_full || do_pop);

    rep_d     = rep_q;
    last_pc_d = last_pc_q;
    if (accept) begin
      last_pc_d = wb_pc;
      // rep_q==0 marks "no commit since reset", so the first commit restarts at 1
      if ((rep_q != '0) && (wb_pc == last_pc_q)) begin
        rep_d = (rep_q == REP_MAX) ? REP_MAX : rep_q + 1'b1;
      end else begin
        rep_d = REP_ONE;
      end
    end
    halt_trig = accept && ((wb_instr == HALT_INSTR) || (rep_d == REP_MAX));

    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rstn) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Next-state logic: halt on trigger, finish once the trace is drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (halt_trig) state_d = HALTED;
      HALTED:  if (count_d == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    halted = (state_q != RUN);
    done   = (state_q == DONE);
  end

  // Counters, repeat tracker and halt PC capture.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cycle_q    <= '0;
      instret_q  <= '0;
      halt_pc_q  <= '0;
      last_pc_q  <= '0;
      rep_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (state_q == RUN) cycle_q <= cycle_q + 64'd1;
      if (accept) instret_q <= instret_q + 64'd1;
      if (halt_trig) halt_pc_q <= wb_pc;
      last_pc_q <= last_pc_d;
      rep_q     <= rep_d;
      if (accept && !do_push) overflow_q <= 1'b1;
    end
  end

  // Trace FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < TRACE_DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_pc_q[wr_ptr_q]    <= wb_pc;
        mem_instr_q[wr_ptr_q] <= wb_instr;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Output drive; head fields read zero while the FIFO is empty.
  always_comb begin
    trace_valid    = (count_q != '0);
    trace_pc       = trace_valid ? mem_pc_q[rd_ptr_q]    : '0;
    trace_instr    = trace_valid ? mem_instr_q[rd_ptr_q] : '0;
    trace_count    = count_q;
    trace_overflow = overflow_q;
    cycle_cnt      = cycle_q;
    instret_cnt    = instret_q;
    halt_pc        = halt_pc_q;
  end

endmodule

// File: doc/commit_monitor.md
Name: commit_monitor

Overview:
- Retirement-side observer that sits directly downstream of the CPU writeback stage and consumes the committed PC/instruction stream (pcW, instrW).
- Keeps cycle and retired-instruction counters and detects program halt: either a self-loop `jal x0,0` or the same PC committing repeatedly.
- Buffers committed PC/instruction pairs in a small trace FIFO so a bench or debug port can drain them without stalling the core.
- Replaces ad-hoc clock/pc printing in simulation with a synthesizable, checkable block.

Parameters:
- ADDR_SIZE, 32, width of PC and instruction fields
- TRACE_DEPTH, 8, trace FIFO entries (power of two, ≥2)
- HALT_REPEAT, 4, consecutive commits of an identical PC that declare halt (≥2)
- HALT_INSTR, 32'h0000006f, instruction encoding that declares halt immediately (`jal x0,0`)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-high (1 = reset)
- wb_valid  in  1  an instruction commits this cycle
- wb_pc  in  ADDR_SIZE  PC of the committing instruction (pcW)
- wb_instr  in  ADDR_SIZE  encoding of the committing instruction
- trace_rd_en  in  1  pop the trace FIFO head
- trace_valid  out  1  FIFO not empty
- trace_pc  out  ADDR_SIZE  head entry PC (first-word fall-through)
- trace_instr  out  ADDR_SIZE  head entry instruction
- trace_count  out  $clog2(TRACE_DEPTH)+1  current occupancy
- trace_overflow  out  1  sticky: a commit was dropped because the FIFO was full
- cycle_cnt  out  64  cycles since reset while not halted
- instret_cnt  out  64  accepted commits
- halted  out  1  halt detected
- halt_pc  out  ADDR_SIZE  PC that triggered halt
- done  out  1  halted and FIFO fully drained

Behaviour:
- Reset, sampled on clk edge while rstn=1:
  - All outputs and counters go to 0.
  - FIFO storage, pointers and the repeat counter clear.
  - State goes to RUN.
  - Reset mid-operation, including from HALTED or DONE, fully restarts the block.
- States and transitions:
  - RUN: cycle_cnt += 1 every cycle. A commit is accepted when wb_valid=1.
  - RUN → HALTED on an accepted commit where wb_instr==HALT_INSTR, or where the repeat count reaches HALT_REPEAT.
  - HALTED: counters freeze and wb_valid is ignored; FIFO pops continue.
  - HALTED → DONE in the cycle the FIFO becomes empty.
  - If the FIFO is already empty when entering HALTED, DONE follows one cycle later.
  - DONE: terminal until reset.
- Output timing:
  - halted and halt_pc (= wb_pc of the triggering commit) are registered and visible the cycle after the triggering commit.
  - done is 1 only in DONE.
- Accepted-commit effects, all registered one cycle later:
  - instret_cnt += 1.
  - {wb_pc, wb_instr} is pushed into the FIFO.
  - The triggering commit itself is counted and pushed.
- Repeat detection:
  - last_pc holds the PC of the previous accepted commit.
  - If wb_pc==last_pc, rep increments (saturating at HALT_REPEAT); otherwise rep=1.
  - The first commit after reset sets rep=1.
  - Cycles with wb_valid=0 do not reset rep.
- Counters: 64-bit, wrap modulo 2^64 with no flag.
- FIFO:
  - Pop happens when trace_rd_en=1 and not empty. trace_rd_en while empty is ignored.
  - Push while full without a pop: the new entry is dropped, trace_overflow is set (sticky until reset), and instret_cnt still increments.
  - Full with simultaneous push and pop: both occur and occupancy is unchanged.
  - Empty with simultaneous push and pop: the pop is ignored, the push occurs, occupancy becomes 1 (no bypass).
  - Pointers wrap modulo TRACE_DEPTH.
  - trace_pc and trace_instr show the head entry, and read 0 when empty.

Test Plan:
- Reset/idle: hold rstn=1 for 2 cycles, release, 10 cycles with wb_valid=0 → cycle_cnt=10, instret_cnt=0, trace_valid=0, halted=0.
- Commit and drain: commit pc 0x00,0x04,0x08 on consecutive cycles, then pop 3 times → trace reads pc 0x00/0x04/0x08 in order, instret_cnt=3, trace_count returns to 0.
- Halt instruction:
  - Commit pc 0x10 then pc 0x14 with instr 0x0000006f → halted=1 the next cycle, halt_pc=0x14, instret_cnt=2.
  - Further wb_valid ignored and cycle_cnt frozen.
  - After 2 pops, done=1.
- Repeat halt, HALT_REPEAT=4:
  - Commit pc 0x20 ×3, a 2-cycle bubble, then 0x20 again → halted=1, halt_pc=0x20.
  - Commits 0x20,0x24,0x20,0x20,0x20 → no halt.
- Overflow: TRACE_DEPTH=8, 10 commits with no pops → trace_count=8, trace_overflow=1, instret_cnt=10, head pc is the first commit. A simultaneous push and pop when full keeps the count at 8.
- Reset mid-halt: from DONE assert rstn=1 for 1 cycle → all outputs 0, state RUN, and a new commit is accepted.
